// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU defaults, dmem controller state encoding, load/store opcodes
package cpu_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_RD_REQ  = 2'd2,
    ST_RD_DONE = 2'd3
  } dmem_state_e;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

endpackage

// File: rtl/dmem_controller_if.sv
// rtl/dmem_controller_if.sv - CPU-side and memory-side bus of the data memory controller
interface dmem_controller_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              busywait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  // Drives CPU requests and memory responses.
  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  // The controller itself.
  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

endinterface

// File: rtl/dmem_wbuf.sv
// rtl/dmem_wbuf.sv - one-entry posted write buffer with address-compare hit
module dmem_wbuf
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] cmp_addr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              hit
);

  // Load wins over clear so a store can refill the entry on the edge its predecessor drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (addr == cmp_addr);

endmodule

// File: rtl/dmem_controller.sv
// rtl/dmem_controller.sv - data memory controller with posted write buffer and load forwarding
module dmem_controller
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_controller_if.slave   bus
);

  dmem_state_e       state, next_state;
  logic              wb_valid, wb_hit, wb_load, wb_clear;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] readdata_q;
  logic              rd_hit, rd_miss_go, drain_done, wr_accept;

  // A read always wins when both requests are raised; the write is simply not seen.
  assign drain_done = (state == ST_DRAIN) && !bus.mem_busywait;
  assign rd_hit     = bus.read && wb_hit;
  assign rd_miss_go = bus.read && !wb_valid && (state == ST_IDLE);
  assign wr_accept  = bus.write && !bus.read && (!wb_valid || drain_done);

  dmem_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wb_load),
    .clear    (wb_clear),
    .load_addr(bus.address),
    .load_data(bus.writedata),
    .cmp_addr (bus.address),
    .valid    (wb_valid),
    .addr     (wb_addr),
    .data     (wb_data),
    .hit      (wb_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next state: reads only start with an empty buffer, so a pending store always drains first.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (rd_miss_go)    next_state = ST_RD_REQ;
        else if (wb_valid) next_state = ST_DRAIN;
      end
      ST_DRAIN:   if (!bus.mem_busywait) next_state = ST_IDLE;
      ST_RD_REQ:  if (!bus.mem_busywait) next_state = ST_RD_DONE;
      ST_RD_DONE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // CPU-facing outputs: stall decision, buffer control and the forwarding mux.
  always_comb begin
    wb_load      = wr_accept;
    wb_clear     = drain_done;
    bus.readdata = rd_hit ? wb_data : readdata_q;
    bus.busywait = 1'b0;
    if (!rst_n)          bus.busywait = 1'b0;
    else if (bus.read)   bus.busywait = !rd_hit && (state != ST_RD_DONE);
    else if (bus.write)  bus.busywait = !wr_accept;
  end

  // Memory strobes and address/data only change when a transfer is launched or completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_read      <= 1'b0;
      bus.mem_write     <= 1'b0;
      bus.mem_address   <= '0;
      bus.mem_writedata <= '0;
    end else begin
      bus.mem_read  <= (next_state == ST_RD_REQ);
      bus.mem_write <= (next_state == ST_DRAIN);
      if (state == ST_IDLE && next_state == ST_RD_REQ) begin
        bus.mem_address <= bus.address;
      end else if (state == ST_IDLE && next_state == ST_DRAIN) begin
        bus.mem_address   <= wb_addr;
        bus.mem_writedata <= wb_data;
      end
    end
  end

  // Load data register, captured on the completing edge of a memory read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       readdata_q <= '0;
    else if (state == ST_RD_REQ && !bus.mem_busywait) readdata_q <= bus.mem_readdata;
  end

endmodule

// File: tb/tb_dmem_controller.sv
// tb/tb_dmem_controller.sv - randomized self-checking bench with memory model and store scoreboard
module tb_dmem_controller;

  logic clk = 1'b0;
  logic rst_n;

  dmem_controller_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dmem_controller #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_arr [256];
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_wr_q [$];

  int cyc = 0;
  int mem_delay = 0;
  int rd_bursts = 0;
  int rd_start_cyc = 0;
  int wr_done_cyc = 0;
  int last_wr_len = 0;

  int         busy_left = 0;
  int         xfer_len = 0;
  bit         in_xfer = 0;
  bit         stab_valid = 0;
  logic       snap_rd, snap_wr;
  logic [7:0] snap_addr, snap_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: serves strobes with a programmable busy time and scoreboards store order.
  initial begin
    logic [15:0] e;
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_xfer = 0; busy_left = 0; stab_valid = 0;
        bus.mem_busywait = 1'b0;
        continue;
      end
      check_eq("strobe_overlap", {31'd0, bus.mem_read & bus.mem_write}, 0);
      if (stab_valid) begin
        check_eq("stable_strobes", {30'd0, bus.mem_read, bus.mem_write}, {30'd0, snap_rd, snap_wr});
        check_eq("stable_addr", bus.mem_address, snap_addr);
        if (snap_wr) check_eq("stable_wdata", bus.mem_writedata, snap_data);
      end
      if (!in_xfer && (bus.mem_read || bus.mem_write)) begin
        in_xfer   = 1;
        xfer_len  = 0;
        busy_left = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
        if (bus.mem_read) begin
          rd_bursts++;
          rd_start_cyc = cyc;
        end
      end
      if (in_xfer) begin
        xfer_len++;
        if (busy_left > 0) begin
          bus.mem_busywait = 1'b1;
          bus.mem_readdata = 8'($urandom);
          busy_left--;
        end else begin
          bus.mem_busywait = 1'b0;
          if (bus.mem_read) begin
            bus.mem_readdata = mem_arr[bus.mem_address];
          end else begin
            check_eq("wr_expected", {31'd0, exp_wr_q.size() != 0}, 1);
            if (exp_wr_q.size() != 0) begin
              e = exp_wr_q.pop_front();
              check_eq("wr_order_addr", bus.mem_address, e[15:8]);
              check_eq("wr_order_data", bus.mem_writedata, e[7:0]);
            end
            mem_arr[bus.mem_address] = bus.mem_writedata;
            last_wr_len = xfer_len;
            wr_done_cyc = cyc;
          end
          in_xfer = 0;
        end
        stab_valid = bus.mem_busywait;
        snap_rd    = bus.mem_read;
        snap_wr    = bus.mem_write;
        snap_addr  = bus.mem_address;
        snap_data  = bus.mem_writedata;
      end else begin
        stab_valid       = 0;
        bus.mem_busywait = 1'($urandom_range(0, 1));
        bus.mem_readdata = 8'($urandom);
      end
    end
  end

  task automatic do_store(input logic [7:0] a, input logic [7:0] d, output int stalls);
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    stalls = 0;
    #1;
    while (bus.busywait && stalls < 100) begin
      stalls++;
      @(negedge clk); #1;
    end
    if (stalls >= 100) check_eq("store_timeout", stalls, 0);
    ref_mem[a] = d;
    exp_wr_q.push_back({a, d});
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] a, input bit with_write, output logic [7:0] d,
                         output int stalls, output int bursts);
    int b0;
    @(negedge clk);
    b0 = rd_bursts;
    bus.read = 1'b1; bus.write = with_write; bus.address = a; bus.writedata = 8'hEE;
    stalls = 0;
    #1;
    while (bus.busywait && stalls < 100) begin
      stalls++;
      @(negedge clk); #1;
    end
    if (stalls >= 100) check_eq("load_timeout", stalls, 0);
    d = bus.readdata;
    bursts = rd_bursts - b0;
    @(posedge clk); #1;
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      check_eq("idle_busywait", {31'd0, bus.busywait}, 0);
    end
  endtask

  initial begin
    logic [7:0] d, a;
    int st, bu, op;

    rst_n = 1'b0;
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 8'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[8'h20] = 8'h5C; ref_mem[8'h20] = 8'h5C;

    #3;
    bus.read = 1'b1; bus.address = 8'h20;
    #1;
    check_eq("rst_busywait", {31'd0, bus.busywait}, 0);
    check_eq("rst_readdata", bus.readdata, 0);
    check_eq("rst_mem_read", {31'd0, bus.mem_read}, 0);
    check_eq("rst_mem_write", {31'd0, bus.mem_write}, 0);
    check_eq("rst_mem_address", bus.mem_address, 0);
    check_eq("rst_mem_wdata", bus.mem_writedata, 0);
    bus.read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Store then drain with a slow memory.
    mem_delay = 3;
    do_store(8'h10, 8'hAB, st);
    check_eq("store_zero_stall", st, 0);
    idle(8);
    check_eq("store_wr_len", last_wr_len, 4);
    check_eq("store_drained", exp_wr_q.size(), 0);
    mem_delay = 0;
    do_load(8'h10, 1'b0, d, st, bu);
    check_eq("empty_buf_miss_burst", bu, 1);
    check_eq("empty_buf_miss_data", d, 8'hAB);
    check_eq("empty_buf_miss_stall", st, 2);

    // Read miss with two busy cycles.
    mem_delay = 2;
    do_load(8'h20, 1'b0, d, st, bu);
    check_eq("miss_stall", st, 4);
    check_eq("miss_data", d, 8'h5C);
    check_eq("miss_burst", bu, 1);

    // Forwarding hit right behind a store.
    mem_delay = 3;
    do_store(8'h30, 8'h77, st);
    check_eq("fwd_store_stall", st, 0);
    do_load(8'h30, 1'b0, d, st, bu);
    check_eq("fwd_stall", st, 0);
    check_eq("fwd_data", d, 8'h77);
    check_eq("fwd_no_burst", bu, 0);
    idle(8);

    // Back-to-back stores.
    mem_delay = 2;
    do_store(8'h01, 8'h11, st);
    check_eq("b2b_first_stall", st, 0);
    do_store(8'h02, 8'h22, st);
    check_eq("b2b_second_stall", st, 3);
    idle(8);
    check_eq("b2b_drained", exp_wr_q.size(), 0);

    // Read miss behind a buffered store.
    mem_delay = 1;
    do_store(8'h40, 8'h99, st);
    do_load(8'h41, 1'b0, d, st, bu);
    check_eq("behind_stall", st, 6);
    check_eq("behind_data", d, ref_mem[8'h41]);
    check_eq("behind_order", {31'd0, rd_start_cyc > wr_done_cyc}, 1);

    // Simultaneous read and write behaves as a read only.
    mem_delay = 0;
    do_load(8'h50, 1'b1, d, st, bu);
    check_eq("rw_data", d, ref_mem[8'h50]);
    check_eq("rw_stall", st, 2);
    idle(4);
    check_eq("rw_no_store", exp_wr_q.size(), 0);

    // Reset in the middle of a read.
    mem_delay = 5;
    @(negedge clk);
    bus.read = 1'b1; bus.address = 8'h20;
    @(negedge clk); #1;
    check_eq("pre_rst_mem_read", {31'd0, bus.mem_read}, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_mem_read", {31'd0, bus.mem_read}, 0);
    check_eq("mid_rst_mem_write", {31'd0, bus.mem_write}, 0);
    check_eq("mid_rst_busywait", {31'd0, bus.busywait}, 0);
    check_eq("mid_rst_readdata", bus.readdata, 0);
    check_eq("mid_rst_mem_address", bus.mem_address, 0);
    check_eq("mid_rst_mem_wdata", bus.mem_writedata, 0);
    bus.read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_wr_q.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_arr[i];
    mem_delay = 2;
    do_load(8'h20, 1'b0, d, st, bu);
    check_eq("post_rst_stall", st, 4);
    check_eq("post_rst_data", d, 8'h5C);
    check_eq("post_rst_burst", bu, 1);

    // Random traffic over a small address pool so forwarding hits are frequent.
    mem_delay = -1;
    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 9));
      a  = 8'h60 + 8'($urandom_range(0, 7));
      if (op < 4) begin
        do_store(a, 8'($urandom), st);
      end else if (op < 8) begin
        do_load(a, 1'b0, d, st, bu);
        check_eq("rand_load_data", d, ref_mem[a]);
      end else begin
        idle(int'($urandom_range(1, 3)));
      end
    end
    idle(30);
    check_eq("final_drained", exp_wr_q.size(), 0);
    for (int i = 0; i < 256; i++) check_eq("final_mem", mem_arr[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_controller.md
DMEM_CONTROLLER -- requirements
Module: dmem_controller

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 8, data width.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 READ  in  1  CPU load request from control unit, held until BUSYWAIT low at a rising edge.
REQ-006 WRITE  in  1  CPU store request from control unit, held the same way as READ.
REQ-007 ADDRESS  in  ADDR_W  CPU load/store address (ALU result).
REQ-008 WRITEDATA  in  DATA_W  CPU store data.
REQ-009 READDATA  out  DATA_W  load data, registered except for the forwarding path.
REQ-010 BUSYWAIT  out  1  CPU stall, combinational from state and request inputs.
REQ-011 MEM_READ / MEM_WRITE  out  1 each  memory strobes, registered.
REQ-012 MEM_ADDRESS / MEM_WRITEDATA  out  ADDR_W / DATA_W  memory address and data, registered.
REQ-013 MEM_READDATA  in  DATA_W  memory read data.
REQ-014 MEM_BUSYWAIT  in  1  memory busy; a transfer completes at the first rising edge where it is low while a strobe is high.

Function
REQ-015 The block SHALL hold a one-entry posted write buffer with fields valid, addr and data.
REQ-016 The FSM SHALL have four states: IDLE, DRAIN, RD_REQ and RD_DONE.
REQ-017 IDLE SHALL move to DRAIN when the buffer is valid and no read miss is being accepted; otherwise it stays in IDLE.
REQ-018 In DRAIN, MEM_WRITE SHALL be 1 with buffer addr/data; on completion the buffer is cleared and the FSM returns to IDLE.
REQ-019 A write SHALL be accepted when the buffer is empty or its drain completes at the same edge.
- On acceptance, BUSYWAIT=0 in that cycle and the buffer is loaded at the edge (zero-stall store).
REQ-020 A write SHALL be stalled with BUSYWAIT=1 when the buffer is valid and not completing at that edge.
REQ-021 A read whose ADDRESS equals a valid buffer addr (forwarding hit) SHALL complete the same cycle in any state.
- READDATA = buffer data, combinationally.
- BUSYWAIT=0.
- No memory access is issued.
REQ-022 A read miss in IDLE with the buffer empty SHALL assert BUSYWAIT=1, latch ADDRESS and enter RD_REQ.
REQ-023 A read miss with the buffer valid SHALL keep BUSYWAIT=1 until the drain completes, then follow REQ-022.
REQ-024 In RD_REQ, MEM_READ SHALL be 1; on completion MEM_READDATA is registered into READDATA and the FSM enters RD_DONE.
REQ-025 RD_DONE SHALL drive BUSYWAIT=0 for exactly one cycle, then return to IDLE without reissuing the still-asserted READ.
REQ-026 Minimum read-miss stall SHALL be 2 cycles; each additional MEM_BUSYWAIT-high cycle adds 1.
REQ-027 READ and WRITE both high SHALL be treated as READ; WRITE is ignored.
REQ-028 MEM_READ and MEM_WRITE SHALL never be high together, and MEM_* outputs SHALL stay stable while MEM_BUSYWAIT is high.
REQ-029 With no request pending, BUSYWAIT SHALL be 0 regardless of buffer state.

Reset
REQ-030 RESET low SHALL immediately drive the following, independent of CLK:
- FSM to IDLE and buffer valid to 0.
- READDATA, MEM_ADDRESS and MEM_WRITEDATA to 0.
- MEM_READ, MEM_WRITE and BUSYWAIT to 0.
REQ-031 Reset mid-transfer SHALL abandon the transfer; a pending buffered write is discarded.
REQ-032 After RESET rises, the first request SHALL be handled as from IDLE with an empty buffer.

Structure
REQ-033 Shared package cpu_pkg SHALL hold the following:
- ADDR_W/DATA_W defaults.
- The dmem_controller state encoding.
- Load/store opcode constants used by the control unit.
REQ-034 The write buffer SHALL be a sub-module, dmem_wbuf, with load/clear/valid/addr/data and an address-compare hit output.
REQ-035 Total RTL SHALL be 120-400 lines.

Verification
REQ-036 Store then drain: WRITE addr 0x10 data 0xAB with MEM_BUSYWAIT high for 3 cycles -> BUSYWAIT stays 0; MEM_WRITE high 4 cycles at 0x10/0xAB; buffer then empty.
REQ-037 Read miss: READ 0x20, memory returns 0x5C after 2 busy cycles -> BUSYWAIT high 4 cycles; READDATA=0x5C in RD_DONE; single MEM_READ burst.
REQ-038 Forward hit: WRITE 0x30/0x77, next cycle READ 0x30 while draining -> READDATA=0x77 and BUSYWAIT=0 that cycle; no MEM_READ.
REQ-039 Back-to-back stores: WRITE 0x01/0x11 then WRITE 0x02/0x22 with memory busy 2 cycles -> second store stalls until first drain completes; memory sees 0x01 then 0x02.
REQ-040 Read miss behind buffer: WRITE 0x40/0x99 then READ 0x41 -> MEM_WRITE completes before MEM_READ asserts; strobes never overlap.
REQ-041 Reset mid-read: RESET low during RD_REQ -> all outputs 0 immediately; after release, READ 0x20 -> fresh RD_REQ sequence.
